lpf_decimator: RTL and testbench

LPF_DECIMATOR -- requirements
Module: lpf_decimator

---
 rtl/lpf_decimator.sv | 126 ++++++++++++
 tb/tb_lpf_decimator.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/lpf_decimator.sv
// rtl/lpf_decimator.sv - boxcar low-pass filter and power-of-two decimator
// Sums 2^L signed samples per window and emits the floor mean, saturated to the output width.
module lpf_decimator #(
  parameter int INPUT_WIDTH  = 14,
  parameter int OUTPUT_WIDTH = 14,
  parameter int MAX_LOG2_DEC = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [INPUT_WIDTH-1:0]  in_data,
  input  logic                           in_valid,
  input  logic [3:0]                     log2_dec,
  input  logic                           flush,
  output logic signed [OUTPUT_WIDTH-1:0] out_data,
  output logic                           out_valid,
  output logic                           out_sat
);

  localparam int ACC_W  = INPUT_WIDTH + MAX_LOG2_DEC;
  localparam int CNT_W  = MAX_LOG2_DEC + 1;
  localparam int WIDE_W = ((ACC_W > OUTPUT_WIDTH) ? ACC_W : OUTPUT_WIDTH) + 1;
  localparam logic [3:0] MAX_L = 4'(MAX_LOG2_DEC);

  localparam logic signed [WIDE_W-1:0] OUT_MAX =
    {{(WIDE_W-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] OUT_MIN =
    {{(WIDE_W-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

  logic signed [ACC_W-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [3:0]                     l_q, l_d;
  logic                           open_q, open_d;
  logic signed [OUTPUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                           out_valid_q, out_valid_d;
  logic                           out_sat_q, out_sat_d;

  logic [3:0]                     l_req;
  logic [3:0]                     l_win;
  logic signed [ACC_W-1:0]        sum;
  logic [CNT_W-1:0]               cnt_inc;
  logic [CNT_W-1:0]               win_len;
  logic                           done;
  logic signed [ACC_W-1:0]        mean;
  logic signed [WIDE_W-1:0]       mean_w;
  logic signed [OUTPUT_WIDTH-1:0] sat_data;
  logic                           sat_hit;

  // The ratio is only sampled when a window opens; an open window keeps its latched L.
  always_comb begin
    l_req   = (log2_dec > MAX_L) ? MAX_L : log2_dec;
    l_win   = open_q ? l_q : l_req;
    sum     = acc_q + ACC_W'(in_data);
    cnt_inc = cnt_q + CNT_W'(1);
    win_len = CNT_W'(1) << l_win;
    done    = (cnt_inc == win_len);
    mean    = sum >>> l_win;
    mean_w  = WIDE_W'(mean);
  end

  // Clipping can only trigger when the output is narrower than the input.
  always_comb begin
    sat_data = mean_w[OUTPUT_WIDTH-1:0];
    sat_hit  = 1'b0;
    if (mean_w > OUT_MAX) begin
      sat_data = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
      sat_hit  = 1'b1;
    end else if (mean_w < OUT_MIN) begin
      sat_data = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
      sat_hit  = 1'b1;
    end
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    l_d         = l_q;
    open_d      = open_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_sat_d   = 1'b0;
    if (flush) begin
      acc_d  = '0;
      cnt_d  = '0;
      open_d = 1'b0;
    end else if (in_valid) begin
      l_d = l_win;
      if (done) begin
        acc_d       = '0;
        cnt_d       = '0;
        open_d      = 1'b0;
        out_data_d  = sat_data;
        out_valid_d = 1'b1;
        out_sat_d   = sat_hit;
      end else begin
        acc_d  = sum;
        cnt_d  = cnt_inc;
        open_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      l_q         <= '0;
      open_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      l_q         <= l_d;
      open_q      <= open_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_lpf_decimator.sv
// tb/tb_lpf_decimator.sv - randomized self-checking bench for lpf_decimator
// A window-list reference model predicts every output cycle; directed cases pin known values.
module tb_lpf_decimator;

  localparam int IW = 14;
  localparam int OW = 12;
  localparam int ML = 10;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [IW-1:0] in_data = '0;
  logic                 in_valid = 1'b0;
  logic [3:0]           log2_dec = '0;
  logic                 flush = 1'b0;
  logic signed [OW-1:0] out_data;
  logic                 out_valid;
  logic                 out_sat;

  lpf_decimator #(
    .INPUT_WIDTH (IW),
    .OUTPUT_WIDTH(OW),
    .MAX_LOG2_DEC(ML)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .log2_dec (log2_dec),
    .flush    (flush),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_sat  (out_sat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int     win[$];
  int     win_l = 0;
  bit     win_open = 1'b0;
  longint m_data = 0;
  bit     e_valid = 1'b0;
  bit     e_sat = 1'b0;

  int     strobes = 0;
  longint last_out = 0;
  bit     last_sat = 1'b0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: collect a window's samples, then take the floor mean and clip it.
  task automatic model(input bit r, input bit v, input int d, input int l, input bit f);
    longint s, n, q;
    e_valid = 1'b0;
    e_sat   = 1'b0;
    if (r) begin
      win.delete();
      win_open = 1'b0;
      m_data   = 0;
    end else if (f) begin
      win.delete();
      win_open = 1'b0;
    end else if (v) begin
      if (!win_open) begin
        win_l    = (l > ML) ? ML : l;
        win_open = 1'b1;
      end
      win.push_back(d);
      if (win.size() == (1 << win_l)) begin
        s = 0;
        foreach (win[i]) s += win[i];
        n = longint'(1) << win_l;
        q = s / n;
        if ((s % n != 0) && (s < 0)) q = q - 1;
        if (q > 2047) begin
          q = 2047;
          e_sat = 1'b1;
        end else if (q < -2048) begin
          q = -2048;
          e_sat = 1'b1;
        end
        m_data  = q;
        e_valid = 1'b1;
        win.delete();
        win_open = 1'b0;
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input int d, input int l, input bit f);
    rst      = r;
    in_valid = v;
    in_data  = d[IW-1:0];
    log2_dec = l[3:0];
    flush    = f;
    model(r, v, d, l, f);
    @(posedge clk);
    #1;
    check_eq("out_valid", longint'(out_valid), longint'(e_valid));
    check_eq("out_data", longint'(out_data), m_data);
    check_eq("out_sat", longint'(out_sat), longint'(e_sat));
    if (out_valid) begin
      strobes++;
      last_out = out_data;
      last_sat = out_sat;
    end
  endtask

  task automatic idle(input int n, input int l);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, l, 1'b0);
  endtask

  task automatic feed(input int d, input int l, input int gap);
    step(1'b0, 1'b1, d, l, 1'b0);
    idle(gap, l);
  endtask

  int r_l;
  bit r_r, r_v, r_f;
  int r_d;

  initial begin
    #1;
    step(1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b0);
    check_eq("rst_data", longint'(out_data), 0);
    check_eq("rst_valid", longint'(out_valid), 0);

    for (int g = 0; g < 3; g += 2) begin
      strobes = 0;
      feed(100, 2, g); feed(200, 2, g); feed(300, 2, g); feed(400, 2, g);
      idle(2, 2);
      check_eq("mean4_cnt", strobes, 1);
      check_eq("mean4_data", last_out, 250);
    end

    strobes = 0;
    feed(-1, 2, 0); feed(-1, 2, 0); feed(-1, 2, 0); feed(-2, 2, 0);
    idle(1, 2);
    check_eq("floor_neg", last_out, -2);
    feed(5, 0, 0);
    check_eq("l0_first", last_out, 5);
    feed(-7, 0, 0);
    check_eq("l0_second", last_out, -7);

    strobes = 0;
    feed(8, 2, 0); feed(8, 2, 0);
    for (int i = 0; i < 10; i++) feed(8, 3, 0);
    idle(2, 3);
    check_eq("ratio_cnt", strobes, 2);
    check_eq("ratio_data", last_out, 8);

    strobes = 0;
    for (int i = 0; i < 3; i++) feed(1000, 2, 0);
    step(1'b0, 1'b0, 0, 2, 1'b1);
    for (int i = 0; i < 4; i++) feed(8, 2, 0);
    idle(2, 2);
    check_eq("flush_cnt", strobes, 1);
    check_eq("flush_data", last_out, 8);
    strobes = 0;
    for (int i = 0; i < 3; i++) feed(8, 2, 0);
    step(1'b0, 1'b1, 8, 2, 1'b1);
    idle(2, 2);
    check_eq("flush_done_cnt", strobes, 0);

    for (int g = 0; g < 3; g += 2) begin
      feed(8191, 0, g);
      check_eq("sat_hi", last_out, 2047);
      check_eq("sat_hi_flag", longint'(last_sat), 1);
      feed(-8192, 0, g);
      check_eq("sat_lo", last_out, -2048);
      check_eq("sat_lo_flag", longint'(last_sat), 1);
    end

    step(1'b0, 1'b0, 0, 15, 1'b1);
    strobes = 0;
    for (int i = 0; i < 1024; i++) feed(3, (i == 0) ? 15 : 0, 0);
    idle(1, 0);
    check_eq("clamp_cnt", strobes, 1);
    check_eq("clamp_data", last_out, 3);

    r_l = 0;
    for (int c = 0; c < 20000; c++) begin
      r_r = ($urandom_range(0, 999) == 0);
      r_v = ($urandom_range(0, 9) < 7);
      r_f = ($urandom_range(0, 99) == 0);
      r_d = int'($urandom_range(0, 16383)) - 8192;
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 3) == 0) r_l = int'($urandom_range(0, 15));
        else r_l = int'($urandom_range(0, 4));
      end
      step(r_r, r_v, r_d, r_l, r_f);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
